// File: rtl/aes_pkg.sv
// Shared AES SubBytes definitions: S-box tables, byte slicing helpers and
// the engine FSM state encoding.
package aes_pkg;

    // Engine control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } eng_state_t;

    // Forward AES S-box.
    localparam logic [7:0] SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Inverse AES S-box.
    localparam logic [7:0] SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Byte i of a 128-bit state sits at [127-8i -: 8]; byte 0 is the MSB.
    function automatic int byte_msb(input int i);
        return 127 - 8 * i;
    endfunction

    // Extract byte i of a 128-bit state.
    function automatic logic [7:0] get_byte(input logic [127:0] s, input int i);
        return s[byte_msb(i) -: 8];
    endfunction

endpackage

// File: rtl/sub_bytes_engine_if.sv
// Block handshake bundle for the SubBytes engine.
// Both sides use valid/ready: a transfer happens on a rising edge where
// valid and ready are both high; valid, once raised, holds its payload
// stable until that edge, and ready may depend combinationally on state.
interface sub_bytes_engine_if;
    import aes_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;
    eng_state_t   state_dbg;

    modport master (
        output in_valid, in_state, in_inv, out_ready,
        input  in_ready, out_valid, out_state, busy, state_dbg
    );

    modport slave (
        input  in_valid, in_state, in_inv, out_ready,
        output in_ready, out_valid, out_state, busy, state_dbg
    );
endinterface

// File: rtl/sbox_byte.sv
// Single-byte S-box lookup; the inverse table is only built when INV_EN=1.
module sbox_byte
    import aes_pkg::*;
#(
    parameter bit INV_EN = 1'b1
) (
    input  logic [7:0] byte_in,
    input  logic       inv,
    output logic [7:0] byte_out
);

    if (INV_EN) begin : g_fwd_inv
        // Select forward or inverse substitution per block.
        always_comb begin
            byte_out = SBOX_FWD[byte_in];
            if (inv) begin
                byte_out = SBOX_INV[byte_in];
            end
        end
    end else begin : g_fwd_only
        logic unused_inv;
        assign unused_inv = inv;
        // Forward substitution only; inv has no effect.
        always_comb begin
            byte_out = SBOX_FWD[byte_in];
        end
    end

endmodule

// File: rtl/sub_bytes_engine.sv
// Sequential AES SubBytes: pushes a 128-bit state through LANES shared
// S-box lanes, LANES bytes per cycle, starting from byte 0.
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int LANES  = 4,
    parameter bit INV_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    sub_bytes_engine_if.slave  bus
);

    localparam int PASSES = 16 / LANES;
    localparam int CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PASSES - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    eng_state_t       state_q;
    eng_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [127:0]     work_q;
    logic [127:0]     work_d;
    logic             inv_q;
    logic             accept;
    logic             last_pass;
    logic             retire;
    logic [7:0]       lane_in  [LANES];
    logic [7:0]       lane_out [LANES];

    assign accept    = bus.in_valid && bus.in_ready;
    assign retire    = bus.out_valid && bus.out_ready;
    assign last_pass = (cnt_q == CNT_LAST);

    // Gather the bytes handled in the current pass.
    always_comb begin
        for (int g = 0; g < LANES; g++) begin
            lane_in[g] = get_byte(work_q, int'(cnt_q) * LANES + g);
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sbox_byte #(.INV_EN(INV_EN)) u_sbox (
            .byte_in  (lane_in[g]),
            .inv      (inv_q),
            .byte_out (lane_out[g])
        );
    end

    // Scatter substituted bytes back; other bytes pass through unchanged.
    always_comb begin
        work_d = work_q;
        if (state_q == ST_RUN) begin
            for (int g = 0; g < LANES; g++) begin
                work_d[byte_msb(int'(cnt_q) * LANES + g) -: 8] = lane_out[g];
            end
        end
    end

    // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after last pass,
    // DONE -> IDLE when the result is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)    state_d = ST_RUN;
            ST_RUN:  if (last_pass) state_d = ST_DONE;
            ST_DONE: if (retire)    state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Working register, pass counter and per-block direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            work_q <= '0;
            inv_q  <= 1'b0;
        end else if (accept) begin
            cnt_q  <= '0;
            work_q <= bus.in_state;
            inv_q  <= bus.in_inv & INV_EN;
        end else if (state_q == ST_RUN) begin
            cnt_q  <= cnt_q + CNT_W'(1);
            work_q <= work_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_state = work_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.state_dbg = state_q;

endmodule
